// File: rtl/lsu_mem_arbiter_pkg.sv
// lsu_mem_arbiter_pkg: shared sizing constants, sel-width helper and the buffered request struct for the LSU memory arbiter
package VX_gpu_pkg;
   localparam int LSU_NUM_REQS    = 4;
   localparam int LSU_NUM_LANES   = 4;
   localparam int LSU_DATA_SIZE   = 4;
   localparam int LSU_ADDR_WIDTH  = 32;
   localparam int LSU_TAG_WIDTH   = 8;
   localparam int LSU_MAX_PENDING = 8;
   function automatic int sel_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int REQ_SEL_BITS = sel_bits(LSU_NUM_REQS);
   localparam int PEND_BITS    = $clog2(LSU_MAX_PENDING + 1);
   typedef struct packed {
      logic                                          rw;
      logic [LSU_NUM_LANES-1:0]                      mask;
      logic [LSU_NUM_LANES*LSU_ADDR_WIDTH-1:0]       addr;
      logic [LSU_NUM_LANES*LSU_DATA_SIZE*8-1:0]      data;
      logic [LSU_NUM_LANES*LSU_DATA_SIZE-1:0]        byteen;
      logic [LSU_TAG_WIDTH+REQ_SEL_BITS-1:0]         tag;
   } lsu_arb_req_t;
endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// lsu_mem_arbiter_if: requester-side, response-side and memory-side buses of the arbiter; slave = arbiter view, master = environment view
interface lsu_mem_arbiter_if import VX_gpu_pkg::*; #(
   parameter int NUM_REQS   = LSU_NUM_REQS,
   parameter int NUM_LANES  = LSU_NUM_LANES,
   parameter int DATA_SIZE  = LSU_DATA_SIZE,
   parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
   parameter int TAG_WIDTH  = LSU_TAG_WIDTH
);
   localparam int SEL = sel_bits(NUM_REQS);
   localparam int AW  = NUM_LANES * ADDR_WIDTH;
   localparam int DW  = NUM_LANES * DATA_SIZE * 8;
   localparam int BW  = NUM_LANES * DATA_SIZE;
   localparam int MTW = TAG_WIDTH + SEL;
   logic [NUM_REQS-1:0]           req_valid, req_ready, req_rw;
   logic [NUM_REQS*NUM_LANES-1:0] req_mask;
   logic [NUM_REQS*AW-1:0]        req_addr;
   logic [NUM_REQS*DW-1:0]        req_data;
   logic [NUM_REQS*BW-1:0]        req_byteen;
   logic [NUM_REQS*TAG_WIDTH-1:0] req_tag;
   logic [NUM_REQS-1:0]           rsp_valid, rsp_ready;
   logic [NUM_LANES-1:0]          rsp_mask;
   logic [DW-1:0]                 rsp_data;
   logic [TAG_WIDTH-1:0]          rsp_tag;
   logic                          mem_req_valid, mem_req_ready, mem_req_rw;
   logic [NUM_LANES-1:0]          mem_req_mask;
   logic [AW-1:0]                 mem_req_addr;
   logic [DW-1:0]                 mem_req_data;
   logic [BW-1:0]                 mem_req_byteen;
   logic [MTW-1:0]                mem_req_tag;
   logic                          mem_rsp_valid, mem_rsp_ready;
   logic [NUM_LANES-1:0]          mem_rsp_mask;
   logic [DW-1:0]                 mem_rsp_data;
   logic [MTW-1:0]                mem_rsp_tag;
   modport slave (
      input  req_valid, req_rw, req_mask, req_addr, req_data, req_byteen, req_tag, rsp_ready,
             mem_req_ready, mem_rsp_valid, mem_rsp_mask, mem_rsp_data, mem_rsp_tag,
      output req_ready, rsp_valid, rsp_mask, rsp_data, rsp_tag, mem_req_valid, mem_req_rw,
             mem_req_mask, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag, mem_rsp_ready
   );
   modport master (
      output req_valid, req_rw, req_mask, req_addr, req_data, req_byteen, req_tag, rsp_ready,
             mem_req_ready, mem_rsp_valid, mem_rsp_mask, mem_rsp_data, mem_rsp_tag,
      input  req_ready, rsp_valid, rsp_mask, rsp_data, rsp_tag, mem_req_valid, mem_req_rw,
             mem_req_mask, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag, mem_rsp_ready
   );
endinterface

// File: rtl/lsu_mem_arbiter_rr_picker.sv
// lsu_rr_picker: combinational round-robin priority encoder; ports elig/ptr in, one-hot grant, its index and valid out
module lsu_rr_picker #(
   parameter int N   = 4,
   parameter int SEL = 2
) (
   input  logic [N-1:0]   elig,
   input  logic [SEL-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [SEL-1:0] idx,
   output logic           valid
);
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!valid && elig[(int'(ptr) + k) % N]) begin
            valid                          = 1'b1;
            grant[(int'(ptr) + k) % N]     = 1'b1;
            idx                            = SEL'((int'(ptr) + k) % N);
         end
      end
   end
endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin share of one LSU memory port; ports clk/reset, bus (slave), pending_count (per-requester reads in flight), busy
module lsu_mem_arbiter import VX_gpu_pkg::*; #(
   parameter int NUM_REQS    = LSU_NUM_REQS,
   parameter int NUM_LANES   = LSU_NUM_LANES,
   parameter int DATA_SIZE   = LSU_DATA_SIZE,
   parameter int ADDR_WIDTH  = LSU_ADDR_WIDTH,
   parameter int TAG_WIDTH   = LSU_TAG_WIDTH,
   parameter int MAX_PENDING = LSU_MAX_PENDING
) (
   input  logic                          clk,
   input  logic                          reset,
   lsu_mem_arbiter_if.slave              bus,
   output logic [NUM_REQS*PEND_BITS-1:0] pending_count,
   output logic                          busy
);
   localparam int SEL = sel_bits(NUM_REQS);
   localparam int PB  = PEND_BITS;
   localparam int AW  = NUM_LANES * ADDR_WIDTH;
   localparam int DW  = NUM_LANES * DATA_SIZE * 8;
   localparam int BW  = NUM_LANES * DATA_SIZE;
   logic [NUM_REQS-1:0] elig, pick_grant;
   logic [SEL-1:0]      pick_idx, rr_ptr, sel;
   logic                pick_valid, can_load, grant, out_valid, sel_ok, rsp_fire;
   lsu_arb_req_t        out_req;
   lsu_rr_picker #(.N(NUM_REQS), .SEL(SEL)) picker (
      .elig  (elig),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .valid (pick_valid)
   );
   // The output register can take a new request when empty or draining this cycle
   assign can_load      = !out_valid || bus.mem_req_ready;
   assign grant         = pick_valid && can_load && !reset;
   assign bus.req_ready = grant ? pick_grant : '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr    <= '0;
         out_valid <= 1'b0;
      end else begin
         if (grant) rr_ptr <= (pick_idx == SEL'(NUM_REQS - 1)) ? '0 : pick_idx + 1'b1;
         out_valid <= grant || (out_valid && !bus.mem_req_ready);
      end
   end
   // Payload is left unreset; out_valid qualifies it
   always_ff @(posedge clk) begin
      if (grant) out_req <= '{
         rw:     bus.req_rw[pick_idx],
         mask:   bus.req_mask[pick_idx*NUM_LANES +: NUM_LANES],
         addr:   bus.req_addr[pick_idx*AW +: AW],
         data:   bus.req_data[pick_idx*DW +: DW],
         byteen: bus.req_byteen[pick_idx*BW +: BW],
         tag:    {bus.req_tag[pick_idx*TAG_WIDTH +: TAG_WIDTH], pick_idx}
      };
   end
   assign bus.mem_req_valid  = out_valid;
   assign bus.mem_req_rw     = out_req.rw;
   assign bus.mem_req_mask   = out_req.mask;
   assign bus.mem_req_addr   = out_req.addr;
   assign bus.mem_req_data   = out_req.data;
   assign bus.mem_req_byteen = out_req.byteen;
   assign bus.mem_req_tag    = out_req.tag;
   // Responses route by the requester index carried in the tag LSBs
   assign sel               = bus.mem_rsp_tag[SEL-1:0];
   assign sel_ok            = int'(sel) < NUM_REQS;
   assign bus.rsp_valid     = (bus.mem_rsp_valid && sel_ok) ? NUM_REQS'(1) << sel : '0;
   assign bus.mem_rsp_ready = sel_ok ? bus.rsp_ready[sel] : 1'b1;
   assign bus.rsp_tag       = bus.mem_rsp_tag[SEL +: TAG_WIDTH];
   assign bus.rsp_mask      = bus.mem_rsp_mask;
   assign bus.rsp_data      = bus.mem_rsp_data;
   assign rsp_fire          = bus.mem_rsp_valid && bus.mem_rsp_ready;
   assert property (@(posedge clk) disable iff (reset) !(bus.mem_rsp_valid && !sel_ok));
   for (genvar i = 0; i < NUM_REQS; i++) begin : g_credit
      logic [PB-1:0] pending;
      logic          inc, dec;
      // Writes bypass the credit check and never take credit
      assign elig[i] = bus.req_valid[i] && (bus.req_rw[i] || int'(pending) < MAX_PENDING);
      assign inc     = bus.req_ready[i] && !bus.req_rw[i];
      assign dec     = rsp_fire && sel_ok && int'(sel) == i;
      always_ff @(posedge clk) begin
         if (reset) pending <= '0;
         else if (inc && !dec) pending <= pending + 1'b1;
         else if (dec && !inc && pending != '0) pending <= pending - 1'b1;
      end
      assign pending_count[i*PB +: PB] = pending;
      assert property (@(posedge clk) disable iff (reset) !(dec && pending == '0));
   end
   assign busy = out_valid || (|pending_count);
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed self-checking bench for lsu_mem_arbiter
module tb_lsu_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] pending_count;
   logic        busy;
   int          tests = 0;
   int          fails = 0;
   int          j, m;
   lsu_mem_arbiter_if bus ();
   lsu_mem_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .pending_count (pending_count),
      .busy          (busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask
   task automatic set_req(input int i, input logic v, input logic rw, input logic [7:0] tag, input logic [31:0] addr);
      bus.req_valid[i]          = v;
      bus.req_rw[i]             = rw;
      bus.req_tag[i*8 +: 8]     = tag;
      bus.req_addr[i*128 +: 32] = addr;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset             = 1'b1;
      bus.req_valid     = '0;
      bus.mem_rsp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask
   initial begin
      bus.req_valid     = '0;
      bus.req_rw        = '0;
      bus.req_mask      = '1;
      bus.req_addr      = '0;
      bus.req_data      = '0;
      bus.req_byteen    = '1;
      bus.req_tag       = '0;
      bus.rsp_ready     = 4'hF;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_mask  = '1;
      bus.mem_rsp_data  = '0;
      bus.mem_rsp_tag   = '0;
      do_reset();
      @(negedge clk);
      chk("rst_mem_valid", bus.mem_req_valid, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_pending", pending_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_rsp_ready", bus.mem_rsp_ready, 1);
      tick();
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 8'(16 + i), 32'(256 + i));
      for (int k = 0; k < 10; k++) begin
         bus.req_valid     = (k < 8) ? 4'hF : 4'h0;
         j                 = (k >= 2) ? (k - 2) % 4 : 0;
         m                 = (k >= 1) ? (k - 1) % 4 : 0;
         bus.mem_rsp_valid = (k >= 2);
         bus.mem_rsp_tag   = {8'(112 + j), 2'(j)};
         @(negedge clk);
         chk("rr_req_ready", bus.req_ready, (k < 8) ? (1 << (k % 4)) : 0);
         chk("rr_mem_valid", bus.mem_req_valid, (k >= 1 && k <= 8) ? 1 : 0);
         if (k >= 1 && k <= 8) begin
            chk("rr_mem_tag", bus.mem_req_tag, {8'(16 + m), 2'(m)});
            chk("rr_mem_addr", bus.mem_req_addr[31:0], 32'(256 + m));
         end
         if (k >= 2) begin
            chk("rr_rsp_valid", bus.rsp_valid, 1 << j);
            chk("rr_rsp_tag", bus.rsp_tag, 8'(112 + j));
         end
         tick();
      end
      bus.mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("rr_drain_pending", pending_count, 0);
      chk("rr_drain_busy", busy, 0);
      tick();
      do_reset();
      set_req(2, 1'b1, 1'b0, 8'h20, 32'h200);
      set_req(1, 1'b0, 1'b1, 8'h11, 32'h110);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("cr_req_ready", bus.req_ready, 4'b0100);
         chk("cr_pending2", pending_count[11:8], k);
         tick();
      end
      bus.req_valid[1] = 1'b1;
      @(negedge clk);
      chk("cr_blocked_write_passes", bus.req_ready, 4'b0010);
      chk("cr_pending2_full", pending_count[11:8], 8);
      tick();
      bus.req_valid[1]  = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_tag   = {8'h20, 2'd2};
      @(negedge clk);
      chk("cr_still_blocked", bus.req_ready, 0);
      chk("cr_rsp_valid", bus.rsp_valid, 4'b0100);
      chk("cr_write_rw", bus.mem_req_rw, 1);
      chk("cr_write_tag", bus.mem_req_tag, {8'h11, 2'd1});
      chk("cr_write_no_credit", pending_count[7:4], 0);
      tick();
      bus.mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("cr_pending2_dec", pending_count[11:8], 7);
      chk("cr_unblocked", bus.req_ready, 4'b0100);
      tick();
      bus.req_valid[2] = 1'b0;
      @(negedge clk);
      chk("cr_pending2_refill", pending_count[11:8], 8);
      tick();
      do_reset();
      bus.mem_req_ready = 1'b0;
      set_req(0, 1'b1, 1'b0, 8'h30, 32'hA0);
      @(negedge clk);
      chk("st_first_grant", bus.req_ready, 4'b0001);
      chk("st_no_valid_yet", bus.mem_req_valid, 0);
      tick();
      set_req(0, 1'b1, 1'b0, 8'h31, 32'hA1);
      set_req(1, 1'b1, 1'b0, 8'h40, 32'hB0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("st_no_ready", bus.req_ready, 0);
         chk("st_valid_held", bus.mem_req_valid, 1);
         chk("st_tag_held", bus.mem_req_tag, {8'h30, 2'd0});
         chk("st_addr_held", bus.mem_req_addr[31:0], 32'hA0);
         tick();
      end
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      chk("st_orig_issues", bus.mem_req_tag, {8'h30, 2'd0});
      chk("st_new_grant", bus.req_ready, 4'b0010);
      tick();
      set_req(1, 1'b0, 1'b0, 8'h40, 32'hB0);
      set_req(0, 1'b1, 1'b0, 8'h32, 32'hA2);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_tag   = {8'h99, 2'd0};
      @(negedge clk);
      chk("st_second_issue", bus.mem_req_tag, {8'h40, 2'd1});
      chk("sc_grant0", bus.req_ready, 4'b0001);
      chk("sc_rsp_valid", bus.rsp_valid, 4'b0001);
      chk("sc_pending0_before", pending_count[3:0], 1);
      tick();
      bus.req_valid     = '0;
      bus.mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("sc_pending0_same", pending_count[3:0], 1);
      chk("sc_pending1", pending_count[7:4], 1);
      chk("sc_issue0", bus.mem_req_tag, {8'h32, 2'd0});
      tick();
      bus.mem_rsp_valid       = 1'b1;
      bus.mem_rsp_tag         = {8'h5A, 2'd3};
      bus.mem_rsp_data[31:0]  = 32'hCAFE_F00D;
      bus.rsp_ready           = 4'b0111;
      @(negedge clk);
      chk("rt_rsp_valid", bus.rsp_valid, 4'b1000);
      chk("rt_rsp_tag", bus.rsp_tag, 8'h5A);
      chk("rt_mem_rsp_ready_low", bus.mem_rsp_ready, 0);
      chk("rt_rsp_data", bus.rsp_data[31:0], 32'hCAFE_F00D);
      bus.rsp_ready = 4'hF;
      #1;
      chk("rt_mem_rsp_ready_high", bus.mem_rsp_ready, 1);
      bus.mem_rsp_valid = 1'b0;
      #1;
      chk("rt_rsp_valid_off", bus.rsp_valid, 0);
      tick();
      bus.mem_req_ready = 1'b0;
      set_req(2, 1'b1, 1'b0, 8'h50, 32'hC0);
      @(negedge clk);
      chk("rs_grant2", bus.req_ready, 4'b0100);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      chk("rs_busy", busy, 1);
      chk("rs_buffered", bus.mem_req_valid, 1);
      chk("rs_pending", pending_count, 16'h0111);
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      chk("rs_mem_valid", bus.mem_req_valid, 0);
      chk("rs_pending_clr", pending_count, 0);
      chk("rs_busy_clr", busy, 0);
      tick();
      reset             = 1'b0;
      bus.mem_req_ready = 1'b1;
      set_req(1, 1'b1, 1'b0, 8'h61, 32'hD1);
      set_req(3, 1'b1, 1'b0, 8'h63, 32'hD3);
      @(negedge clk);
      chk("rs_ptr_zero", bus.req_ready, 4'b0010);
      tick();
      bus.req_valid = '0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lsu_mem_arbiter.md
# lsu_mem_arbiter

Round-robin arbiter that shares one LSU memory port between `NUM_REQS` LSU blocks inside the core, placed between the execute stage's `lsu_mem_if` array and the memory unit. Requester index is appended to the request tag so responses route back to their requester. Per-requester outstanding-load credit counters bound in-flight reads. A registered output stage gives full-throughput, one-cycle grant-to-issue latency.

## Interface
- `NUM_REQS`, 4: number of LSU requesters (= `NUM_LSU_BLOCKS`); `REQ_SEL_BITS = max(1, CLOG2(NUM_REQS))`.
- `NUM_LANES`, 4: lanes per request (= `NUM_LSU_LANES`).
- `DATA_SIZE`, 4: bytes per lane word.
- `ADDR_WIDTH`, 32: per-lane word address width.
- `TAG_WIDTH`, 8: requester-side tag width; memory-side tag is `TAG_WIDTH + REQ_SEL_BITS`, with the index in the LSBs.
- `MAX_PENDING`, 8: maximum outstanding reads per requester.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `req_valid`/`req_ready` in/out `NUM_REQS`: per-requester request handshake.
- `req_rw`, `req_mask`, `req_addr`, `req_data`, `req_byteen`, `req_tag` in, flattened `NUM_REQS`×{1, `NUM_LANES`, `NUM_LANES*ADDR_WIDTH`, `NUM_LANES*DATA_SIZE*8`, `NUM_LANES*DATA_SIZE`, `TAG_WIDTH`}: request payload.
- `rsp_valid`/`rsp_ready` out/in `NUM_REQS`: per-requester response handshake.
- `rsp_mask`, `rsp_data`, `rsp_tag` out, shared across requesters: response payload, qualified by `rsp_valid[i]`.
- `mem_req_valid`/`mem_req_ready` out/in 1; `mem_req_rw`, `mem_req_mask`, `mem_req_addr`, `mem_req_data`, `mem_req_byteen` out: same widths as one requester.
- `mem_req_tag` out `TAG_WIDTH+REQ_SEL_BITS`: extended tag.
- `mem_rsp_valid`/`mem_rsp_ready` in/out 1; `mem_rsp_mask`, `mem_rsp_data`, `mem_rsp_tag` in: memory response.
- `pending_count` out `NUM_REQS*CLOG2(MAX_PENDING+1)`: per-requester outstanding reads.
- `busy` out 1: high when any pending count is nonzero or the output stage is full.

## Operation
- Eligibility: `elig[i] = req_valid[i] && (req_rw[i] || pending[i] < MAX_PENDING)`. Writes never consume credit and produce no response.
- Arbitration: round-robin over `elig`, searching upward from pointer `rr_ptr` with wrap-around. The grant is taken only when the output stage can accept (`!out_valid || mem_req_ready`).
- `req_ready[i]` is high only for the granted index. It never depends on `req_valid[i]` of other requesters beyond arbitration.
- On grant of `i`: `rr_ptr <= (i+1) mod NUM_REQS`. With no grant, `rr_ptr` holds.
- Output stage: a single register holding the payload, `mem_req_tag = {req_tag[i], i}`, and `out_valid`. It loads on grant, clears when `mem_req_ready` is high and there is no new grant. Simultaneous drain and load is allowed.
- Credit: `pending[i]` increments on a read grant for `i` and decrements on `mem_rsp_valid && mem_rsp_ready` with `mem_rsp_tag[REQ_SEL_BITS-1:0] == i`. When both happen in the same cycle the count is unchanged.
- Response routing:
  - `sel = mem_rsp_tag[REQ_SEL_BITS-1:0]`.
  - `rsp_valid[sel] = mem_rsp_valid`; all other `rsp_valid` bits are 0.
  - `mem_rsp_ready = rsp_ready[sel]`.
  - `rsp_tag = mem_rsp_tag >> REQ_SEL_BITS`; mask and data pass through.
- Error: a response for a requester whose `pending` is 0 fires a simulation assertion; the counter saturates at 0. A `sel >= NUM_REQS` response also asserts and is dropped (`mem_rsp_ready = 1`).
- Reset: `rr_ptr = 0`, `out_valid = 0`, all `pending = 0`. The payload registers are not reset. Reset mid-transaction discards the buffered request and all credit state.

## Timing
- Request latency: grant in cycle N gives `mem_req_valid` in N+1. Sustained throughput is 1 request/cycle while `mem_req_ready` stays high.
- `mem_req_*` stays stable while `mem_req_valid && !mem_req_ready`.
- Response path is combinational (0 cycles). The block adds no bubbles.
- Reset values: `mem_req_valid = 0`, `req_ready = 0`, `rsp_valid = 0`, `pending_count = 0`, `busy = 0`. `mem_rsp_ready` follows `rsp_ready` combinationally.
- `NUM_REQS = 1`: arbitration degenerates to pass-through, and the tag still gets a 1-bit index of 0.

## Structure
- Put the derived constants `REQ_SEL_BITS` and `PEND_BITS` and the packed request struct type `lsu_arb_req_t` in `VX_gpu_pkg`.
- Single sub-module `lsu_rr_picker`: combinational round-robin priority encoder taking `elig`/`rr_ptr` and producing a one-hot grant plus its index. It is reused for the pointer update.
- Credit counters are a `for` generate over requesters. Perf counting of grants and stalls is left to the instantiating core.

## Test plan
- All 4 requesters continuously issue reads, `mem_req_ready = 1`, responses returned 1 cycle later -> grants in order 0,1,2,3,0,… with one `mem_req_valid` per cycle; tags are `{tag,idx}`.
- Requester 2 issues 8 reads with no responses -> 9th read blocked (`req_ready[2] = 0`) while requester 1 writes still pass; one response with idx 2 -> `pending[2]` goes 8→7 and the blocked read is granted the next cycle.
- `mem_req_ready` held low 5 cycles with `out_valid = 1` -> `mem_req_*` stable and no `req_ready` asserted; ready released -> original request issues first, then a new grant the same cycle.
- In the same cycle, a read grant to requester 0 and a response to requester 0 -> `pending[0]` unchanged.
- Response with tag `{0x5A, idx 3}` and `rsp_ready[3] = 0` -> `rsp_valid = 4'b1000`, `rsp_tag = 0x5A`, `mem_rsp_ready = 0` until `rsp_ready[3]` rises.
- Assert reset with 3 pending reads and a buffered request -> next cycle `mem_req_valid = 0`, all `pending_count = 0`, `busy = 0`, `rr_ptr = 0`.
